// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/LSU memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } arb_owner_t;

  // Request latched at grant time and held on the memory port until accepted.
  typedef struct packed {
    logic                    we;
    logic [ARB_ADDR_W-1:0]   addr;
    logic [ARB_DATA_W-1:0]   wdata;
    logic [ARB_DATA_W/8-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_starve_guard.sv
// Fetch anti-starvation counter: counts LSU grants taken while fetch waits and
// forces a fetch grant once MAX_LS_BURST of them have happened back to back.
module arb_starve_guard #(
  parameter int MAX_LS_BURST = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_idle,
  input  logic i_if_req,
  input  logic i_if_grant,
  input  logic i_ls_grant,
  output logic o_force_if
);

  localparam int CNT_W = $clog2(MAX_LS_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LS_BURST);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (i_if_grant || (i_idle && !i_if_req)) begin
      cnt_next = '0;
    end else if (i_ls_grant && i_if_req && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign o_force_if = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and LSU, LSU priority, flush squashing.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int MAX_LS_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_wmask,
  output logic              o_ls_ack,
  output logic              o_ls_valid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic              i_mem_ready,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  input  logic [31:0]       i_log_fd
);

  arb_state_t        state_reg, state_next;
  arb_owner_t        owner_reg, owner_next;
  mem_req_t          req_reg, req_next;
  logic              squash_reg, squash_next;
  logic              done_reg, done_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              force_if, can_grant, pick_ls, grant_if, grant_ls;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_guard #(
    .MAX_LS_BURST(MAX_LS_BURST)
  ) u_starve_guard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_idle     (state_reg == IDLE),
    .i_if_req   (i_if_req),
    .i_if_grant (grant_if),
    .i_ls_grant (grant_ls),
    .o_force_if (force_if)
  );
`else
  logic unused_burst_cfg;
  assign unused_burst_cfg = (MAX_LS_BURST > 0);
  assign force_if = 1'b0;
`endif

  // No grant during the response pulse, so the next grant lands one cycle later.
  assign can_grant = (state_reg == IDLE) && !done_reg && !i_flush && !i_rst;
  assign pick_ls   = i_ls_req && !(force_if && i_if_req);
  assign grant_ls  = can_grant && pick_ls;
  assign grant_if  = can_grant && !pick_ls && i_if_req;

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    req_next    = req_reg;
    squash_next = squash_reg;
    rdata_next  = rdata_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        squash_next = 1'b0;
        if (grant_ls) begin
          owner_next     = OWN_LS;
          req_next.we    = i_ls_we;
          req_next.addr  = i_ls_addr;
          req_next.wdata = i_ls_wdata;
          req_next.wmask = i_ls_wmask;
          state_next     = REQ;
        end else if (grant_if) begin
          owner_next     = OWN_IF;
          req_next.we    = 1'b0;
          req_next.addr  = i_if_addr;
          req_next.wdata = '0;
          req_next.wmask = '0;
          state_next     = REQ;
        end
      end
      REQ: begin
        if (i_flush) squash_next = 1'b1;
        if (i_mem_ready) state_next = WAIT;
      end
      WAIT: begin
        if (i_flush) squash_next = 1'b1;
        if (i_mem_valid) begin
          rdata_next  = i_mem_rdata;
          done_next   = !(squash_reg || i_flush);
          squash_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      owner_reg  <= OWN_IF;
      req_reg    <= '0;
      squash_reg <= 1'b0;
      done_reg   <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      req_reg    <= req_next;
      squash_reg <= squash_next;
      done_reg   <= done_next;
      rdata_reg  <= rdata_next;
    end
  end

  assign o_if_ack    = grant_if;
  assign o_ls_ack    = grant_ls;
  assign o_if_valid  = done_reg && (owner_reg == OWN_IF);
  assign o_ls_valid  = done_reg && (owner_reg == OWN_LS);
  assign o_if_rdata  = rdata_reg;
  assign o_ls_rdata  = rdata_reg;
  assign o_mem_req   = (state_reg == REQ);
  assign o_mem_we    = req_reg.we;
  assign o_mem_addr  = req_reg.addr;
  assign o_mem_wdata = req_reg.wdata;
  assign o_mem_wmask = req_reg.wmask;
  assign o_busy      = (state_reg != IDLE) || done_reg;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if ((state_reg == REQ) && i_mem_valid)
        $error("mem_port_arbiter: memory response before request was accepted");
      if (i_log_fd != 32'd0) begin
        if (grant_if) $display("arb grant if addr=%h", i_if_addr);
        if (grant_ls) $display("arb grant ls we=%b addr=%h", i_ls_we, i_ls_addr);
        if ((state_reg == WAIT) && i_mem_valid) begin
          if (squash_reg || i_flush) $display("arb squash owner=%s", owner_reg.name());
          else $display("arb resp owner=%s data=%h", owner_reg.name(), i_mem_rdata);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus corner sequences,
// with a response scoreboard checked by a monitor on every cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_wmask;
  logic        if_ack, if_valid, ls_ack, ls_valid;
  logic [31:0] if_rdata, ls_rdata;
  logic        mem_req, mem_we, mem_ready, mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        busy;
  logic [31:0] log_fd;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LS_BURST(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack),
    .o_if_valid(if_valid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata), .i_ls_wmask(ls_wmask), .o_ls_ack(ls_ack),
    .o_ls_valid(ls_valid), .o_ls_rdata(ls_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_ready(mem_ready), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata),
    .o_busy(busy), .i_log_fd(log_fd)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
  } resp_t;
  resp_t sb[$];

  typedef struct {
    logic        use_if;
    logic        use_ls;
    logic [31:0] if_addr;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    int          rdy_dly;
    int          vld_dly;
    logic        exp_first_ls;
  } vec_t;
  vec_t vecs[4];

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Response monitor: every valid pulse must match the head of the scoreboard.
  resp_t mon_e;
  always @(negedge clk) begin
    #2;
    if (if_ack && ls_ack) chkb("dual_ack", 1'b1, 1'b0);
    if (if_valid || ls_valid) begin
      if (sb.size() == 0) begin
        chkw("unexpected_valid", {30'd0, if_valid, ls_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chkb("valid_owner_ls", ls_valid, mon_e.is_ls);
        chkb("valid_owner_if", if_valid, !mon_e.is_ls);
        chkw("resp_rdata", mon_e.is_ls ? ls_rdata : if_rdata, mon_e.data);
        $display("resp owner=%s data=%h", mon_e.is_ls ? "ls" : "if", mon_e.data);
      end
    end
  end

  // Called just after a negedge with requests already driven; returns in the
  // response pulse cycle (just after its negedge).
  task automatic do_txn(input string tag, input logic exp_ls, input int exp_lat,
                        input logic [31:0] exp_addr, input logic exp_we,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wmask,
                        input logic [31:0] rdata, input int rdy_dly, input int vld_dly);
    int   lat;
    logic got_ls;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (if_ack || ls_ack) begin
        lat = k;
        break;
      end
    end
    chkw({tag, "_ack_latency"}, 32'(lat), 32'(exp_lat));
    if (lat < 0) return;
    got_ls = ls_ack;
    chkb({tag, "_ack_owner_ls"}, ls_ack, exp_ls);
    @(negedge clk);
    if (got_ls) ls_req = 1'b0;
    else if_req = 1'b0;
    #1;
    chkb({tag, "_mem_req"}, mem_req, 1'b1);
    chkw({tag, "_mem_addr"}, mem_addr, exp_addr);
    chkb({tag, "_mem_we"}, mem_we, exp_we);
    chkw({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
    chkw({tag, "_mem_wmask"}, 32'(mem_wmask), 32'(exp_wmask));
    chkb({tag, "_busy_req"}, busy, 1'b1);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      #1;
      chkb({tag, "_mem_req_held"}, mem_req, 1'b1);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chkb({tag, "_mem_req_dropped"}, mem_req, 1'b0);
    chkb({tag, "_busy_wait"}, busy, 1'b1);
    for (int i = 0; i < vld_dly; i++) begin
      @(negedge clk);
      #1;
    end
    mem_valid = 1'b1;
    mem_rdata = rdata;
    sb.push_back('{got_ls, rdata});
    $display("txn %s owner=%s addr=%h we=%b rdata=%h", tag, got_ls ? "ls" : "if",
             exp_addr, exp_we, rdata);
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0; log_fd = 32'd0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 4'h0,
                32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'hF,
                32'h0000_0000, 32'h1234_5678, 0, 0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_4004, 32'h0, 4'h3,
                32'hA5A5_5A5A, 32'h0, 2, 3, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 4'h0,
                32'hFFFF_FFFF, 32'h0, 1, 0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    if_req = 1'b1; ls_req = 1'b1;
    #1;
    chkb("rst_if_ack", if_ack, 1'b0);
    chkb("rst_ls_ack", ls_ack, 1'b0);
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_valid", if_valid | ls_valid, 1'b0);
    chkw("rst_if_rdata", if_rdata, 32'h0);
    chkw("rst_ls_rdata", ls_rdata, 32'h0);
    chkw("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    $display("reset checked");

    // Table-driven transactions
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      if_req = vecs[v].use_if; if_addr = vecs[v].if_addr;
      ls_req = vecs[v].use_ls; ls_we = vecs[v].ls_we; ls_addr = vecs[v].ls_addr;
      ls_wdata = vecs[v].ls_wdata; ls_wmask = vecs[v].ls_wmask;
      if (vecs[v].exp_first_ls)
        do_txn($sformatf("v%0d_a", v), 1'b1, 0, vecs[v].ls_addr, vecs[v].ls_we,
               vecs[v].ls_wdata, vecs[v].ls_wmask, vecs[v].rdata_a,
               vecs[v].rdy_dly, vecs[v].vld_dly);
      else
        do_txn($sformatf("v%0d_a", v), 1'b0, 0, vecs[v].if_addr, 1'b0, 32'h0, 4'h0,
               vecs[v].rdata_a, vecs[v].rdy_dly, vecs[v].vld_dly);
      if (vecs[v].use_if && vecs[v].use_ls)
        do_txn($sformatf("v%0d_b", v), 1'b0, 1, vecs[v].if_addr, 1'b0, 32'h0, 4'h0,
               vecs[v].rdata_b, vecs[v].rdy_dly, vecs[v].vld_dly);
    end

    // Flush in IDLE blocks the grant for that cycle only
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_5000; flush = 1'b1;
    #1;
    chkb("flush_idle_if_ack", if_ack, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    do_txn("flush_idle", 1'b0, 0, 32'h0000_5000, 1'b0, 32'h0, 4'h0, 32'h0000_55AA, 0, 0);

    // Flush in WAIT: response consumed, no valid, port free right after
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_6000;
    #1;
    chkb("sqw_if_ack", if_ack, 1'b1);
    @(negedge clk);
    if_req = 1'b0; mem_ready = 1'b1;
    #1;
    chkb("sqw_mem_req", mem_req, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0; flush = 1'b1;
    #1;
    chkb("sqw_busy_flush", busy, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chkb("sqw_busy_t3", busy, 1'b1);
    @(negedge clk);
    mem_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chkb("sqw_busy_t4", busy, 1'b1);
    @(negedge clk);
    mem_valid = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_7000; ls_wdata = 32'h0; ls_wmask = 4'hF;
    #1;
    chkb("sqw_busy_fell", busy, 1'b0);
    chkb("sqw_no_if_valid", if_valid, 1'b0);
    do_txn("post_squash", 1'b1, 0, 32'h0000_7000, 1'b0, 32'h0, 4'hF, 32'h7777_7777, 0, 1);
    $display("flush in WAIT checked");

    // Flush in REQ on a store: request stays up until accepted, no completion
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_7100; ls_wdata = 32'h1111_2222; ls_wmask = 4'h5;
    #1;
    chkb("sqr_ls_ack", ls_ack, 1'b1);
    @(negedge clk);
    ls_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; mem_ready = 1'b1;
    #1;
    chkb("sqr_mem_req_kept", mem_req, 1'b1);
    chkb("sqr_mem_we_kept", mem_we, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0; mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    chkb("sqr_no_ls_valid", ls_valid, 1'b0);
    chkb("sqr_busy", busy, 1'b0);
    $display("flush in REQ checked");

    // Reset mid-transaction
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_8000;
    #1;
    chkb("rreq_if_ack", if_ack, 1'b1);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chkb("rreq_mem_req", mem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chkb("rreq_mem_req_low", mem_req, 1'b0);
    chkb("rreq_busy_low", busy, 1'b0);
    @(negedge clk);
    mem_valid = 1'b1; mem_rdata = 32'h0000_0099;
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    chkb("rreq_no_if_valid", if_valid, 1'b0);
    chkb("rreq_no_ls_valid", ls_valid, 1'b0);
    $display("reset in REQ checked");

    // Continuous LSU stream with fetch pending
    for (int n = 0; n < 6; n++) begin
      logic exp_ls;
`ifdef ARB_STARVE_GUARD_EN
      exp_ls = (n != 4);
`else
      exp_ls = 1'b1;
`endif
      if (n == 0) begin
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_9000;
      end
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_A000 + 32'(n * 4);
      ls_wdata = 32'(n); ls_wmask = 4'hF;
      if (exp_ls)
        do_txn($sformatf("burst%0d", n), 1'b1, (n == 0) ? 0 : 1, ls_addr, 1'b1,
               ls_wdata, 4'hF, 32'(n + 100), 0, 0);
      else
        do_txn($sformatf("burst%0d", n), 1'b0, 1, 32'h0000_9000, 1'b0, 32'h0, 4'h0,
               32'hF00D_0004, 0, 0);
    end
`ifndef ARB_STARVE_GUARD_EN
    do_txn("burst_if", 1'b0, 1, 32'h0000_9000, 1'b0, 32'h0, 4'h0, 32'hF00D_0006, 0, 0);
`endif

    repeat (3) @(negedge clk);
    #1;
    chkw("scoreboard_empty", 32'(sb.size()), 32'd0);
    chkb("final_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
